// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the fetch/decode pipeline
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef struct packed {
        word_t npc;
        word_t instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of {npc, instr} decoupling fetch from decode
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  word_t            enq_npc,
    input  word_t            enq_instr,
    output logic             deq_valid,
    input  logic             deq_ready,
    output word_t            deq_npc,
    output word_t            deq_instr,
    output logic [PTR_W:0]   count
);
    fq_entry_t        mem [DEPTH];
    fq_entry_t        head;
    logic [PTR_W-1:0] rptr, wptr;
    logic [PTR_W:0]   cnt;
    logic             do_enq, do_deq;
    assign enq_ready = cnt != (PTR_W+1)'(DEPTH);
    assign deq_valid = cnt != '0;
    assign do_enq    = enq_valid && enq_ready && !flush;
    assign do_deq    = deq_valid && deq_ready && !flush;
    // Head is masked so decode never sees stale storage.
    assign head      = deq_valid ? mem[rptr] : '0;
    assign deq_npc   = head.npc;
    assign deq_instr = head.instr;
    assign count     = cnt;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_enq) begin
                mem[wptr] <= '{npc: enq_npc, instr: enq_instr};
                wptr      <= wptr + 1'b1;
            end
            if (do_deq) rptr <= rptr + 1'b1;
            if (do_enq != do_deq) cnt <= do_enq ? cnt + 1'b1 : cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with DEPTH = 4
module tb_fetch_queue;
    import cpu_types_pkg::*;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    word_t       enq_npc = '0;
    word_t       enq_instr = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    word_t       deq_npc;
    word_t       deq_instr;
    logic [2:0]  count;
    int          vectors = 0;
    int          errors = 0;
    logic [31:0] q[$];

    fetch_queue #(.DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_npc(enq_npc), .enq_instr(enq_instr),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_npc(deq_npc), .deq_instr(deq_instr),
        .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic ev [10];
        logic dr [10];
        ev = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
        dr = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        // reset held for two cycles
        tick();
        tick();
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_instr", deq_instr, 32'h0);
        nRST = 1'b1;
        tick();
        // fill with no dequeue
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_npc   = 32'(4 * (i + 1));
            enq_instr = 32'hA0 + 32'(i);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        check("full_enq_ready", 32'(enq_ready), 32'd0);
        enq_npc   = 32'h14;
        enq_instr = 32'hA4;
        tick();
        check("full_refuse_count", 32'(count), 32'd4);
        check("full_head", deq_instr, 32'hA0);
        // drain in order
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_instr", deq_instr, 32'hA0 + 32'(i));
            check("drain_npc", deq_npc, 32'(4 * (i + 1)));
            tick();
            if (i == 0) check("drain_enq_ready", 32'(enq_ready), 32'd1);
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_deq_valid", 32'(deq_valid), 32'd0);
        check("drain_no_stale", deq_instr, 32'h0);
        // streaming: each word visible one cycle after its enqueue
        enq_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enq_npc   = 32'h1000 + 32'(4 * i);
            enq_instr = 32'h100 + 32'(i);
            if (i > 0) begin
                check("stream_instr", deq_instr, 32'h100 + 32'(i - 1));
                check("stream_count", 32'(count), 32'd1);
            end else begin
                check("stream_first_empty", 32'(deq_valid), 32'd0);
            end
            tick();
        end
        enq_valid = 1'b0;
        check("stream_last", deq_instr, 32'h113);
        tick();
        check("stream_end_count", 32'(count), 32'd0);
        // wrap-around with an occupancy ramp, checked against a queue model
        for (int i = 0; i < 10; i++) begin
            enq_valid = ev[i];
            deq_ready = dr[i];
            enq_instr = 32'hC0 + 32'(i);
            enq_npc   = 32'h2000 + 32'(i);
            check("wrap_count", 32'(count), 32'(q.size()));
            check("wrap_head", deq_instr, q.size() != 0 ? q[0] : 32'h0);
            tick();
            if (dr[i] && q.size() != 0) void'(q.pop_front());
            if (ev[i]) q.push_back(32'hC0 + 32'(i));
        end
        check("wrap_final_count", 32'(count), 32'(q.size()));
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        // flush with three entries, colliding with enq and deq
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_instr = 32'hD0 + 32'(i);
            tick();
        end
        check("pre_flush_count", 32'(count), 32'd3);
        flush     = 1'b1;
        enq_instr = 32'hBB;
        deq_ready = 1'b1;
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_deq_valid", 32'(deq_valid), 32'd0);
        check("flush_deq_instr", deq_instr, 32'h0);
        enq_valid = 1'b1;
        enq_instr = 32'hCC;
        tick();
        enq_valid = 1'b0;
        check("post_flush_head", deq_instr, 32'hCC);
        check("post_flush_count", 32'(count), 32'd1);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check("post_flush_drained", 32'(count), 32'd0);
        // asynchronous reset between edges
        enq_valid = 1'b1;
        enq_npc   = 32'h3000;
        enq_instr = 32'hE0;
        tick();
        enq_instr = 32'hE1;
        tick();
        enq_valid = 1'b0;
        check("pre_areset_count", 32'(count), 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        check("areset_count", 32'(count), 32'd0);
        check("areset_deq_valid", 32'(deq_valid), 32'd0);
        check("areset_enq_ready", 32'(enq_ready), 32'd1);
        check("areset_deq_instr", deq_instr, 32'h0);
        check("areset_deq_npc", deq_npc, 32'h0);
        nRST = 1'b1;
        tick();
        check("post_areset_count", 32'(count), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
